// File: rtl/cache_fill_fsm_pkg.sv
// Shared constants, state encoding and address helpers for the cache fill engine.
package cache_fill_fsm_pkg;

  localparam int ADDR_WIDTH      = 16;
  localparam int DATA_WIDTH      = 16;
  localparam int WORDS_PER_BLOCK = 8;
  localparam int OFFSET_BITS     = 4;
  localparam int WORD_BYTES      = 2;
  localparam int CNT_WIDTH       = 4;

  typedef enum logic {
    FILL_IDLE   = 1'b0,
    FILL_ACTIVE = 1'b1
  } fill_state_e;

  // Block base address: the byte address with the in-block offset bits cleared.
  function automatic logic [ADDR_WIDTH-1:0] block_base(input logic [ADDR_WIDTH-1:0] addr);
    block_base = addr & ~ADDR_WIDTH'((1 << OFFSET_BITS) - 1);
  endfunction

  // Byte offset of word number cnt inside a block.
  function automatic logic [ADDR_WIDTH-1:0] word_offset(input logic [CNT_WIDTH-1:0] cnt);
    word_offset = ADDR_WIDTH'(cnt) * ADDR_WIDTH'(WORD_BYTES);
  endfunction

endpackage

// File: rtl/cache_fill_fsm_fill_counter.sv
// Small up-counter with synchronous clear and a terminal-count flag.
module fill_counter #(
  parameter int WIDTH    = 4,
  parameter int TERMINAL = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  output logic [WIDTH-1:0] count,
  output logic             terminal
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  // Clear wins over increment so a finishing fill can restart from zero.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count    = cnt_q;
  assign terminal = (cnt_q == WIDTH'(TERMINAL));

endmodule

// File: rtl/cache_fill_fsm.sv
// Miss-handling engine: fetches an 8-word block from main memory, writes each
// returned word into the data array and finally writes the tag/valid entry.
module cache_fill_fsm
  import cache_fill_fsm_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  miss_detected,
  input  logic [ADDR_WIDTH-1:0] miss_address,
  input  logic [DATA_WIDTH-1:0] memory_data,
  input  logic                  memory_data_valid,
  output logic                  fsm_busy,
  output logic                  mem_read_en,
  output logic [ADDR_WIDTH-1:0] memory_address,
  output logic                  write_data_array,
  output logic                  write_tag_array,
  output logic [ADDR_WIDTH-1:0] fill_address,
  output logic [DATA_WIDTH-1:0] fill_data
);

  fill_state_e           state_q;
  fill_state_e           state_d;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [ADDR_WIDTH-1:0] base_d;

  logic [CNT_WIDTH-1:0]  req_cnt;
  logic [CNT_WIDTH-1:0]  rsp_cnt;
  logic                  req_all_issued;
  logic                  rsp_is_last;
  logic                  cnt_clear;
  logic                  req_advance;
  logic                  rsp_accept;

  // Counts read requests issued; terminal once every word of the block is requested.
  fill_counter #(
    .WIDTH    (CNT_WIDTH),
    .TERMINAL (WORDS_PER_BLOCK)
  ) u_req_counter (
    .clk      (clk),
    .rst      (rst),
    .clear    (cnt_clear),
    .enable   (req_advance),
    .count    (req_cnt),
    .terminal (req_all_issued)
  );

  // Counts responses written; terminal means the next accepted response is the last word.
  fill_counter #(
    .WIDTH    (CNT_WIDTH),
    .TERMINAL (WORDS_PER_BLOCK - 1)
  ) u_rsp_counter (
    .clk      (clk),
    .rst      (rst),
    .clear    (cnt_clear),
    .enable   (rsp_accept),
    .count    (rsp_cnt),
    .terminal (rsp_is_last)
  );

  // State and block base registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FILL_IDLE;
      base_q  <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
    end
  end

  // Next state: capture the block on a miss, return to idle after the last word lands.
  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    cnt_clear = 1'b0;
    case (state_q)
      FILL_IDLE: begin
        if (miss_detected) begin
          state_d   = FILL_ACTIVE;
          base_d    = block_base(miss_address);
          cnt_clear = 1'b1;
        end
      end
      FILL_ACTIVE: begin
        if (rsp_accept && rsp_is_last) begin
          state_d   = FILL_IDLE;
          cnt_clear = 1'b1;
        end
      end
      default: begin
        state_d   = FILL_IDLE;
        cnt_clear = 1'b1;
      end
    endcase
  end

  // Outputs: issue reads until all are out, write each in-order response, tag on the last.
  always_comb begin
    fsm_busy         = 1'b0;
    mem_read_en      = 1'b0;
    req_advance      = 1'b0;
    rsp_accept       = 1'b0;
    write_data_array = 1'b0;
    write_tag_array  = 1'b0;
    memory_address   = base_q + word_offset(req_cnt);
    fill_address     = base_q + word_offset(rsp_cnt);
    fill_data        = memory_data;
    if (state_q == FILL_ACTIVE) begin
      fsm_busy    = 1'b1;
      mem_read_en = !req_all_issued;
      req_advance = !req_all_issued;
      if (memory_data_valid && (rsp_cnt != req_cnt)) begin
        rsp_accept       = 1'b1;
        write_data_array = 1'b1;
        write_tag_array  = rsp_is_last;
      end
    end
  end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Directed self-checking bench for cache_fill_fsm with an in-order, fixed-latency memory model.
module tb_cache_fill_fsm;

  logic        clk = 1'b0;
  logic        rst;
  logic        miss_detected;
  logic [15:0] miss_address;
  logic [15:0] memory_data;
  logic        memory_data_valid;
  logic        fsm_busy;
  logic        mem_read_en;
  logic [15:0] memory_address;
  logic        write_data_array;
  logic        write_tag_array;
  logic [15:0] fill_address;
  logic [15:0] fill_data;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int mem_lat = 4;
  bit spur_valid = 1'b0;

  typedef struct {
    logic [15:0] addr;
    int          due;
  } req_t;
  req_t pend_q[$];

  cache_fill_fsm dut (
    .clk               (clk),
    .rst               (rst),
    .miss_detected     (miss_detected),
    .miss_address      (miss_address),
    .memory_data       (memory_data),
    .memory_data_valid (memory_data_valid),
    .fsm_busy          (fsm_busy),
    .mem_read_en       (mem_read_en),
    .memory_address    (memory_address),
    .write_data_array  (write_data_array),
    .write_tag_array   (write_tag_array),
    .fill_address      (fill_address),
    .fill_data         (fill_data)
  );

  always #5 clk = ~clk;

  // Memory content: a fixed scramble of the word address.
  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h3C5A;
  endfunction

  // Record each read request mid-cycle together with the cycle its data is due.
  always @(negedge clk) begin
    if (!rst && mem_read_en) begin
      pend_q.push_back('{memory_address, cyc + mem_lat});
    end
  end

  // Advance the cycle count and drive the response (or a forced spurious valid) for the new cycle.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rst) begin
      pend_q.delete();
    end
    #1;
    if (pend_q.size() > 0 && pend_q[0].due == cyc) begin
      memory_data_valid = 1'b1;
      memory_data       = mem_word(pend_q[0].addr);
      void'(pend_q.pop_front());
    end else if (spur_valid) begin
      memory_data_valid = 1'b1;
      memory_data       = 16'hDEAD;
    end else begin
      memory_data_valid = 1'b0;
      memory_data       = 16'($urandom);
    end
  end

  // Full fill with per-cycle expectations; cycle 0 is the cycle the miss is presented.
  task automatic run_fill(input logic [15:0] addr, input int lat, input bit pulse,
                          input bit spur1, input string tag);
    logic [15:0] base;
    logic [15:0] exp_a;
    logic        exp_busy;
    logic        exp_rd;
    logic        exp_wda;
    logic        exp_wta;
    int          nwr;
    int          ntag;
    base    = addr & 16'hFFF0;
    nwr     = 0;
    ntag    = 0;
    mem_lat = lat;
    @(posedge clk);
    #2;
    miss_detected = 1'b1;
    miss_address  = addr;
    for (int rel = 0; rel <= 9 + lat; rel++) begin
      @(negedge clk);
      exp_busy = (rel >= 1) && (rel <= 8 + lat);
      exp_rd   = (rel >= 1) && (rel <= 8);
      exp_wda  = (rel >= 1 + lat) && (rel <= 8 + lat);
      exp_wta  = (rel == 8 + lat);
      if (write_data_array === 1'b1) nwr++;
      if (write_tag_array === 1'b1) ntag++;
      checks++;
      if (fsm_busy !== exp_busy) begin
        errors++;
        $display("[TB] FAIL %s busy rel=%0d got %b exp %b", tag, rel, fsm_busy, exp_busy);
      end
      checks++;
      if (mem_read_en !== exp_rd) begin
        errors++;
        $display("[TB] FAIL %s read_en rel=%0d got %b exp %b", tag, rel, mem_read_en, exp_rd);
      end
      if (exp_rd) begin
        exp_a = base + 16'(2 * (rel - 1));
        checks++;
        if (memory_address !== exp_a) begin
          errors++;
          $display("[TB] FAIL %s mem_addr rel=%0d got %h exp %h", tag, rel, memory_address, exp_a);
        end
      end
      checks++;
      if (write_data_array !== exp_wda) begin
        errors++;
        $display("[TB] FAIL %s wr_data rel=%0d got %b exp %b", tag, rel, write_data_array, exp_wda);
      end
      if (exp_wda) begin
        exp_a = base + 16'(2 * (rel - 1 - lat));
        checks++;
        if (fill_address !== exp_a) begin
          errors++;
          $display("[TB] FAIL %s fill_addr rel=%0d got %h exp %h", tag, rel, fill_address, exp_a);
        end
        checks++;
        if (fill_data !== mem_word(exp_a)) begin
          errors++;
          $display("[TB] FAIL %s fill_data rel=%0d got %h exp %h", tag, rel, fill_data, mem_word(exp_a));
        end
      end
      checks++;
      if (write_tag_array !== exp_wta) begin
        errors++;
        $display("[TB] FAIL %s wr_tag rel=%0d got %b exp %b", tag, rel, write_tag_array, exp_wta);
      end
      if (rel == 0 && spur1) spur_valid = 1'b1;
      if (rel == 1) begin
        spur_valid = 1'b0;
        if (pulse) miss_address = 16'hBEE4;
        else miss_detected = 1'b0;
      end
      if (rel == 9 + lat) miss_detected = 1'b0;
    end
    checks++;
    if (nwr != 8) begin
      errors++;
      $display("[TB] FAIL %s write_count got %0d exp 8", tag, nwr);
    end
    checks++;
    if (ntag != 1) begin
      errors++;
      $display("[TB] FAIL %s tag_count got %0d exp 1", tag, ntag);
    end
  endtask

  // Two reset cycles with random inputs, then every control output must be low.
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #2;
      miss_detected = 1'($urandom_range(0, 1));
      miss_address  = 16'($urandom);
      spur_valid    = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    checks++;
    if (fsm_busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset busy got %b exp 0", fsm_busy);
    end
    checks++;
    if (mem_read_en !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset read_en got %b exp 0", mem_read_en);
    end
    checks++;
    if (write_data_array !== 1'b0 || write_tag_array !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset writes got %b%b exp 00", write_data_array, write_tag_array);
    end
    checks++;
    if (memory_address !== 16'h0000 || fill_address !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL reset addrs got %h/%h exp 0000/0000", memory_address, fill_address);
    end
    rst           = 1'b0;
    miss_detected = 1'b0;
    spur_valid    = 1'b0;
  endtask

  task automatic test_basic_fill();
    run_fill(16'h1236, 4, 1'b0, 1'b0, "basic_L4");
  endtask

  task automatic test_latency();
    run_fill(16'h2468, 1, 1'b0, 1'b0, "lat1");
    run_fill(16'h7ABC, 8, 1'b0, 1'b1, "lat8_spur");
  endtask

  // First fill sees a miss held high throughout, including its completion cycle.
  task automatic test_back_to_back();
    run_fill(16'h00F0, 2, 1'b1, 1'b0, "b2b_first");
    run_fill(16'hFF02, 3, 1'b0, 1'b0, "b2b_second");
  endtask

  // Reset in cycle 6 of a fill aborts it without a tag write; a clean fill follows.
  task automatic test_reset_abort();
    logic exp_busy;
    logic exp_rd;
    logic exp_wda;
    mem_lat = 3;
    @(posedge clk);
    #2;
    miss_detected = 1'b1;
    miss_address  = 16'h4A16;
    for (int rel = 0; rel <= 10; rel++) begin
      @(negedge clk);
      exp_busy = (rel >= 1) && (rel <= 6);
      exp_rd   = (rel >= 1) && (rel <= 6);
      exp_wda  = (rel >= 4) && (rel <= 6);
      checks++;
      if (fsm_busy !== exp_busy) begin
        errors++;
        $display("[TB] FAIL abort busy rel=%0d got %b exp %b", rel, fsm_busy, exp_busy);
      end
      checks++;
      if (mem_read_en !== exp_rd) begin
        errors++;
        $display("[TB] FAIL abort read_en rel=%0d got %b exp %b", rel, mem_read_en, exp_rd);
      end
      checks++;
      if (write_data_array !== exp_wda) begin
        errors++;
        $display("[TB] FAIL abort wr_data rel=%0d got %b exp %b", rel, write_data_array, exp_wda);
      end
      checks++;
      if (write_tag_array !== 1'b0) begin
        errors++;
        $display("[TB] FAIL abort wr_tag rel=%0d got %b exp 0", rel, write_tag_array);
      end
      if (rel == 1) miss_detected = 1'b0;
      if (rel == 6) rst = 1'b1;
      if (rel == 7) rst = 1'b0;
    end
    run_fill(16'h4A1E, 2, 1'b0, 1'b0, "after_abort");
  endtask

  // Valid with nothing outstanding: ignored in IDLE here, and in FILL via the spur option.
  task automatic test_spurious();
    spur_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (write_data_array !== 1'b0 || fsm_busy !== 1'b0) begin
        errors++;
        $display("[TB] FAIL idle_spur wr/busy got %b/%b exp 0/0", write_data_array, fsm_busy);
      end
      checks++;
      if (fill_address !== 16'h4A10 || memory_address !== 16'h4A10) begin
        errors++;
        $display("[TB] FAIL idle_spur addrs got %h/%h exp 4a10/4a10", fill_address, memory_address);
      end
    end
    spur_valid = 1'b0;
    run_fill(16'h0C0A, 5, 1'b0, 1'b1, "fill_spur");
  endtask

  // Scenario sequence and summary.
  initial begin
    rst           = 1'b1;
    miss_detected = 1'b0;
    miss_address  = 16'h0000;
    test_reset();
    test_basic_fill();
    test_latency();
    test_back_to_back();
    test_reset_abort();
    test_spurious();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Time bound so the run always ends.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
